// File: rtl/mbt_pkg.sv
// Shared definitions for the multibit-tree node matcher: op codes,
// the output-register state encoding and the response flag bundle.
package mbt_pkg;

    // Operation codes presented on op_code
    localparam logic [1:0] OP_SEARCH    = 2'b00;
    localparam logic [1:0] OP_SET       = 2'b01;
    localparam logic [1:0] OP_CLEAR     = 2'b10;
    localparam logic [1:0] OP_CLEAR_ALL = 2'b11;

    // One-deep response register: EMPTY means rsp_valid is low
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } mbt_state_t;

    // Response flags; the index travels separately because its width
    // depends on the node width parameter
    typedef struct packed {
        logic found;
        logic wrap;
        logic err;
    } mbt_rsp_t;

endpackage

// File: rtl/mbt_ripple_chain.sv
// Combinational ripple priority chain built from matcher cells. Each cell
// sees its data bit, its mask bit and a ripple-in that is high once any
// lower cell has already claimed the hit. The lowest qualifying cell wins.
module mbt_ripple_chain #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] mask,
    output logic [WIDTH-1:0] hit,
    output logic             any_hit
);

    // ripple[i] is high when some cell below i already produced a hit
    logic [WIDTH:0] ripple;

    assign ripple[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_cell
            logic cand;
            assign cand          = data[gi] & mask[gi];
            assign hit[gi]       = cand & ~ripple[gi];
            assign ripple[gi+1]  = ripple[gi] | cand;
        end
    endgenerate

    // The final ripple-out is simply "some cell matched"
    assign any_hit = ripple[WIDTH];

endmodule

// File: rtl/mbt_node_matcher.sv
// One tree node of the multibit-tree tag sorter. Holds a WIDTH-bit
// occupancy bitmap and serves SET / CLEAR / CLEAR_ALL / SEARCH operations
// through a valid/ready op port and a one-deep registered response port.
// SEARCH returns the first occupied slot at or above op_idx, optionally
// wrapping around to slot 0 when nothing is found above.
module mbt_node_matcher
    import mbt_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int WRAP  = 1,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       op_code,
    input  logic [IDX_W-1:0] op_idx,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_found,
    output logic [IDX_W-1:0] rsp_idx,
    output logic             rsp_wrap,
    output logic             rsp_err,
    output logic [WIDTH-1:0] bitmap
);

    // Node width widened by one bit so op_idx can be range-checked even when
    // WIDTH is an exact power of two (the check then never fires)
    localparam logic [IDX_W:0] WIDTH_L = WIDTH[IDX_W:0];

    mbt_state_t       state_reg;
    logic [WIDTH-1:0] bitmap_reg;
    logic [WIDTH-1:0] bitmap_next;
    mbt_rsp_t         rsp_reg;
    mbt_rsp_t         rsp_next;
    logic [IDX_W-1:0] rsp_idx_reg;
    logic [IDX_W-1:0] rsp_idx_next;

    logic             accept;
    logic             idx_err;
    logic [WIDTH-1:0] search_mask;
    logic [WIDTH-1:0] target_sel;
    logic [WIDTH-1:0] hit_main;
    logic [WIDTH-1:0] hit_wrap;
    logic             any_main;
    logic             any_wrap;
    logic [IDX_W-1:0] idx_main;
    logic [IDX_W-1:0] idx_wrap;

    // Handshake: the response register can take a new op whenever it is
    // empty or is being drained in the same cycle; nothing enters in reset
    assign rsp_valid = (state_reg == ST_FULL);
    assign op_ready  = !rst && (!rsp_valid || rsp_ready);
    assign accept    = op_valid && op_ready;

    // Only meaningful for non-power-of-two widths
    assign idx_err = ({1'b0, op_idx} >= WIDTH_L);

    // Per-slot decode of op_idx: thermometer mask for the first search pass
    // and a one-hot select for SET/CLEAR. An out-of-range index selects
    // no slot at all.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_decode
            assign search_mask[gi] = (IDX_W'(gi) >= op_idx);
            assign target_sel[gi]  = (IDX_W'(gi) == op_idx);
        end
    endgenerate

    // Pass 1: slots at or above the query index
    mbt_ripple_chain #(
        .WIDTH (WIDTH)
    ) u_pass_main (
        .data    (bitmap_reg),
        .mask    (search_mask),
        .hit     (hit_main),
        .any_hit (any_main)
    );

    // Pass 2: the whole bitmap, used only when pass 1 misses and WRAP is set
    mbt_ripple_chain #(
        .WIDTH (WIDTH)
    ) u_pass_wrap (
        .data    (bitmap_reg),
        .mask    ({WIDTH{1'b1}}),
        .hit     (hit_wrap),
        .any_hit (any_wrap)
    );

    // One-hot to binary encoders for both passes (OR of the set positions)
    always_comb begin
        idx_main = '0;
        idx_wrap = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (hit_main[i]) idx_main = idx_main | IDX_W'(i);
            if (hit_wrap[i]) idx_wrap = idx_wrap | IDX_W'(i);
        end
    end

    // Next bitmap and response for the op on the port; committed only on accept.
    // SEARCH reads bitmap_reg, i.e. the state before this edge.
    always_comb begin
        bitmap_next  = bitmap_reg;
        rsp_next     = '0;
        rsp_idx_next = '0;
        case (op_code)
            OP_SET: begin
                rsp_idx_next = op_idx;
                rsp_next.err = idx_err;
                if (!idx_err) bitmap_next = bitmap_reg | target_sel;
            end
            OP_CLEAR: begin
                rsp_idx_next = op_idx;
                rsp_next.err = idx_err;
                if (!idx_err) bitmap_next = bitmap_reg & ~target_sel;
            end
            OP_CLEAR_ALL: begin
                bitmap_next = '0;
            end
            OP_SEARCH: begin
                // An out-of-range query reports only err; idx stays 0 as for a miss
                if (idx_err) begin
                    rsp_next.err = 1'b1;
                end else if (any_main) begin
                    rsp_next.found = 1'b1;
                    rsp_idx_next   = idx_main;
                end else if ((WRAP != 0) && any_wrap) begin
                    rsp_next.found = 1'b1;
                    rsp_next.wrap  = 1'b1;
                    rsp_idx_next   = idx_wrap;
                end
            end
            default: begin
                bitmap_next = bitmap_reg;
            end
        endcase
    end

    // Output-register FSM plus bitmap state; fields hold while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_EMPTY;
            bitmap_reg  <= '0;
            rsp_reg     <= '0;
            rsp_idx_reg <= '0;
        end else begin
            case (state_reg)
                ST_EMPTY: if (accept) state_reg <= ST_FULL;
                ST_FULL:  if (!accept && rsp_ready) state_reg <= ST_EMPTY;
                default:  state_reg <= ST_EMPTY;
            endcase
            if (accept) begin
                bitmap_reg  <= bitmap_next;
                rsp_reg     <= rsp_next;
                rsp_idx_reg <= rsp_idx_next;
            end
        end
    end

    assign rsp_found = rsp_reg.found;
    assign rsp_wrap  = rsp_reg.wrap;
    assign rsp_err   = rsp_reg.err;
    assign rsp_idx   = rsp_idx_reg;
    assign bitmap    = bitmap_reg;

endmodule
